program_loader: RTL

Host-side writer into the instruction/data memory that the CPU controller fetches from.
- Accepts a byte stream (from the board UART receiver or switch-entry logic) carrying a framed program image.
- Assembles the bytes into 16-bit words and writes them to consecutive memory addresses.
- Holds the CPU stopped while loading, and reports completion or error.

---
 rtl/loader_pkg.sv | 36 +++
 rtl/program_loader_if.sv | 25 ++
 rtl/loader_checksum.sv | 27 ++
 rtl/program_loader.sv | 161 ++++++++++++++++
 4 files changed

// File: rtl/loader_pkg.sv
// Shared types and frame geometry for the program loader.
package loader_pkg;

  localparam int unsigned BYTE_W     = 8;
  localparam int unsigned LEN_BYTES  = 2;
  localparam int unsigned WORD_BYTES = 2;
  localparam int unsigned CSUM_BYTES = 1;
  localparam int unsigned LEN_W      = LEN_BYTES * BYTE_W;
  localparam int unsigned WORD_W     = WORD_BYTES * BYTE_W;
  localparam int unsigned CSUM_W     = CSUM_BYTES * BYTE_W;

  localparam logic [CSUM_W-1:0] CSUM_INIT = 8'h00;

  typedef enum logic [3:0] {
    S_IDLE,
    S_LEN_HI,
    S_LEN_LO,
    S_DATA_HI,
    S_DATA_LO,
    S_WRITE,
    S_CSUM,
    S_DONE,
    S_ERROR
  } state_e;

  // States in which a byte from the stream is consumed.
  function automatic logic takes_byte(state_e s);
    return s inside {S_LEN_HI, S_LEN_LO, S_DATA_HI, S_DATA_LO, S_CSUM};
  endfunction

  // States that make up an in-progress load.
  function automatic logic is_busy(state_e s);
    return s inside {S_LEN_HI, S_LEN_LO, S_DATA_HI, S_DATA_LO, S_WRITE, S_CSUM};
  endfunction

endpackage

// File: rtl/program_loader_if.sv
// Byte stream in and memory write port out of the program loader.
interface program_loader_if
  import loader_pkg::*;
#(
  parameter int unsigned ADDR_W = 8
);

  logic [BYTE_W-1:0] rx_data;
  logic              rx_valid;
  logic              rx_ready;
  logic [ADDR_W-1:0] mem_addr;
  logic [WORD_W-1:0] mem_wdata;
  logic              mem_we;

  modport master (
    input  rx_data, rx_valid,
    output rx_ready, mem_addr, mem_wdata, mem_we
  );

  modport slave (
    output rx_data, rx_valid,
    input  rx_ready, mem_addr, mem_wdata, mem_we
  );

endinterface

// File: rtl/loader_checksum.sv
// Running XOR of frame bytes, with a compare against the trailing checksum byte.
module loader_checksum
  import loader_pkg::*;
(
  input  logic              clock,
  input  logic              reset,
  input  logic              clear,
  input  logic              enable,
  input  logic [CSUM_W-1:0] data,
  output logic              match_c
);

  logic [CSUM_W-1:0] acc;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      acc <= CSUM_INIT;
    end else if (clear) begin
      acc <= CSUM_INIT;
    end else if (enable) begin
      acc <= acc ^ data;
    end
  end

  assign match_c = (acc == data);

endmodule

// File: rtl/program_loader.sv
// Loads a framed program image from a byte stream into instruction memory,
// holding the CPU stopped while the load is in flight.
module program_loader
  import loader_pkg::*;
#(
  parameter int unsigned ADDR_W    = 8,
  parameter int unsigned BASE_ADDR = 0
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  input  logic              abort,
  program_loader_if.master  bus,
  output logic              cpu_hold,
  output logic              busy,
  output logic              done,
  output logic              error,
  output logic [ADDR_W:0]   words_loaded
);

  localparam int unsigned CNT_W = ADDR_W + 1;
  localparam int unsigned CMP_W = LEN_W + 1;
  localparam logic [CMP_W-1:0] CAPACITY = CMP_W'(1) << ADDR_W;

  state_e            state;
  state_e            state_n;
  logic [BYTE_W-1:0] len_hi;
  logic [LEN_W-1:0]  len;
  logic [BYTE_W-1:0] data_hi;
  logic [LEN_W-1:0]  len_full;
  logic              xfer;
  logic              go;
  logic              acc_en;
  logic              csum_ok;

  assign xfer     = bus.rx_valid && bus.rx_ready;
  assign len_full = {len_hi, bus.rx_data};

  loader_checksum u_checksum (
    .clock   (clock),
    .reset   (reset),
    .clear   (go),
    .enable  (acc_en),
    .data    (bus.rx_data),
    .match_c (csum_ok)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state <= S_IDLE;
    end else begin
      state <= state_n;
    end
  end

  // Abort takes priority over everything, including a byte arriving that cycle.
  always_comb begin
    state_n = state;
    go      = 1'b0;
    acc_en  = 1'b0;
    if (abort && is_busy(state)) begin
      state_n = S_ERROR;
    end else begin
      case (state)
        S_IDLE, S_ERROR: begin
          if (start) begin
            state_n = S_LEN_HI;
            go      = 1'b1;
          end
        end
        S_LEN_HI: begin
          if (xfer) begin
            acc_en  = 1'b1;
            state_n = S_LEN_LO;
          end
        end
        S_LEN_LO: begin
          if (xfer) begin
            acc_en = 1'b1;
            if (len_full == '0) begin
              state_n = S_CSUM;
            end else if (CMP_W'(len_full) > CAPACITY) begin
              state_n = S_ERROR;
            end else begin
              state_n = S_DATA_HI;
            end
          end
        end
        S_DATA_HI: begin
          if (xfer) begin
            acc_en  = 1'b1;
            state_n = S_DATA_LO;
          end
        end
        S_DATA_LO: begin
          if (xfer) begin
            acc_en  = 1'b1;
            state_n = S_WRITE;
          end
        end
        S_WRITE: begin
          if (CMP_W'(words_loaded) + CMP_W'(1) < CMP_W'(len)) begin
            state_n = S_DATA_HI;
          end else begin
            state_n = S_CSUM;
          end
        end
        S_CSUM: begin
          if (xfer) begin
            state_n = csum_ok ? S_DONE : S_ERROR;
          end
        end
        S_DONE:  state_n = S_IDLE;
        default: state_n = S_IDLE;
      endcase
    end
  end

  // Status outputs are decoded from the next state so they line up with it.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      bus.rx_ready  <= 1'b0;
      bus.mem_we    <= 1'b0;
      bus.mem_addr  <= ADDR_W'(BASE_ADDR);
      bus.mem_wdata <= '0;
      cpu_hold      <= 1'b0;
      busy          <= 1'b0;
      done          <= 1'b0;
      error         <= 1'b0;
      words_loaded  <= '0;
      len_hi        <= '0;
      len           <= '0;
      data_hi       <= '0;
    end else begin
      bus.rx_ready <= takes_byte(state_n);
      bus.mem_we   <= (state_n == S_WRITE);
      cpu_hold     <= (state_n != S_IDLE);
      busy         <= is_busy(state_n);
      done         <= (state_n == S_DONE);
      error        <= (state_n == S_ERROR);
      if (go) begin
        bus.mem_addr <= ADDR_W'(BASE_ADDR);
        words_loaded <= '0;
      end
      if (state == S_WRITE && state_n != S_ERROR) begin
        bus.mem_addr <= bus.mem_addr + ADDR_W'(1);
        words_loaded <= words_loaded + CNT_W'(1);
      end
      if (acc_en) begin
        case (state)
          S_LEN_HI:  len_hi        <= bus.rx_data;
          S_LEN_LO:  len           <= len_full;
          S_DATA_HI: data_hi       <= bus.rx_data;
          S_DATA_LO: bus.mem_wdata <= {data_hi, bus.rx_data};
          default:   ;
        endcase
      end
    end
  end

endmodule
